// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the Wishbone round-robin arbiter: FSM encoding,
// watchdog counter width and grant-index width helper.
package wbarb_pkg;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StBusy = 1'b1
  } state_e;

  localparam int unsigned TMO_W = 8;

  // Grant index width; a single-bit index is kept even for NM <= 2.
  function automatic int unsigned idx_w(input int unsigned n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Bus bundle between NM Wishbone masters, the arbiter and the peripheral side.
// With WBARB_LOCK_EN defined, a per-master m_lock vector is added.
interface wb_arbiter_if #(
  parameter int unsigned NM = 2,
  parameter int unsigned AW = 15,
  parameter int unsigned DW = 32
);
  logic [NM*AW-1:0] m_adr;
  logic [NM*DW-1:0] m_dat;
  logic [NM-1:0]    m_we;
  logic [NM-1:0]    m_stb;
  logic [DW-1:0]    m_dat_i;
  logic [NM-1:0]    m_ack;
  logic [NM-1:0]    m_err;
  logic [AW-1:0]    s_adr;
  logic [DW-1:0]    s_dat_o;
  logic             s_we;
  logic             s_stb;
  logic [DW-1:0]    s_dat_i;
  logic             s_ack;

`ifdef WBARB_LOCK_EN
  logic [NM-1:0]    m_lock;

  // Arbiter view.
  modport slave (
    input  m_adr, m_dat, m_we, m_stb, m_lock, s_dat_i, s_ack,
    output m_dat_i, m_ack, m_err, s_adr, s_dat_o, s_we, s_stb
  );
  // Environment view: requesting masters plus the peripheral.
  modport master (
    output m_adr, m_dat, m_we, m_stb, m_lock, s_dat_i, s_ack,
    input  m_dat_i, m_ack, m_err, s_adr, s_dat_o, s_we, s_stb
  );
`else
  // Arbiter view.
  modport slave (
    input  m_adr, m_dat, m_we, m_stb, s_dat_i, s_ack,
    output m_dat_i, m_ack, m_err, s_adr, s_dat_o, s_we, s_stb
  );
  // Environment view: requesting masters plus the peripheral.
  modport master (
    output m_adr, m_dat, m_we, m_stb, s_dat_i, s_ack,
    input  m_dat_i, m_ack, m_err, s_adr, s_dat_o, s_we, s_stb
  );
`endif

endinterface

// File: rtl/wb_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr,
// searching upward modulo NM.
module rr_pick
  import wbarb_pkg::*;
#(
  parameter int unsigned NM = 2,
  parameter int unsigned GW = idx_w(NM)
) (
  input  logic [NM-1:0] req,
  input  logic [GW-1:0] ptr,
  output logic [GW-1:0] winner,
  output logic          any
);

  // Scan NM slots starting at ptr; the first asserted request wins.
  always_comb begin
    logic [GW-1:0] j;
    winner = '0;
    any    = 1'b0;
    j      = '0;
    for (int unsigned i = 0; i < NM; i++) begin
      j = GW'((32'(ptr) + i) % NM);
      if (!any && req[j]) begin
        winner = j;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin Wishbone arbiter with bus watchdog. One classic transfer at a
// time; a stalled transfer is terminated with a one-cycle m_err pulse.
// Optional feature macro: WBARB_LOCK_EN (locked back-to-back transfers).
module wb_arbiter
  import wbarb_pkg::*;
#(
  parameter int unsigned NM  = 2,
  parameter int unsigned AW  = 15,
  parameter int unsigned DW  = 32,
  parameter int unsigned TMO = 255
) (
  input  logic        clk,
  input  logic        arst,
  wb_arbiter_if.slave bus,
  output logic        busy
);

  localparam int unsigned GW = idx_w(NM);
  localparam logic [TMO_W-1:0] TmoVal = TMO_W'(TMO);

  state_e           state_q, state_d;
  logic [GW-1:0]    grant_q, grant_d;
  logic [GW-1:0]    ptr_q, ptr_d;
  logic [TMO_W-1:0] count_q, count_d;
  logic [GW-1:0]    sel, winner, grant_nxt;
  logic             any, is_busy, cur_stb, timeout, lock;

  rr_pick #(
    .NM (NM),
    .GW (GW)
  ) u_pick (
    .req    (bus.m_stb),
    .ptr    (ptr_q),
    .winner (winner),
    .any    (any)
  );

  // Bus muxing and per-master handshake; master 0 is presented when idle.
  always_comb begin
    is_busy     = (state_q == StBusy);
    sel         = is_busy ? grant_q : '0;
    bus.s_adr   = '0;
    bus.s_dat_o = '0;
    bus.s_we    = 1'b0;
    cur_stb     = 1'b0;
    for (int unsigned i = 0; i < NM; i++) begin
      if (sel == GW'(i)) begin
        bus.s_adr   = bus.m_adr[i*AW +: AW];
        bus.s_dat_o = bus.m_dat[i*DW +: DW];
        bus.s_we    = bus.m_we[i];
        cur_stb     = bus.m_stb[i];
      end
    end
    timeout     = is_busy && (count_q == TmoVal);
    bus.s_stb   = is_busy && cur_stb && !timeout;
    bus.m_dat_i = bus.s_dat_i;
    bus.m_ack   = '0;
    bus.m_err   = '0;
    if (is_busy) begin
      bus.m_ack[grant_q] = bus.s_ack;
      // Ack beats timeout; an aborted request gets neither.
      bus.m_err[grant_q] = timeout && cur_stb && !bus.s_ack;
    end
    busy = is_busy;
`ifdef WBARB_LOCK_EN
    lock = bus.m_lock[grant_q];
`else
    lock = 1'b0;
`endif
  end

  // Next-state: arbitration in idle, completion/abort/watchdog while busy.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    count_d   = count_q;
    grant_nxt = (grant_q == GW'(NM - 1)) ? '0 : grant_q + GW'(1);
    unique case (state_q)
      StIdle: begin
        if (any) begin
          grant_d = winner;
          count_d = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (bus.s_ack) begin
          if (lock) begin
            count_d = '0;
          end else begin
            state_d = StIdle;
            ptr_d   = grant_nxt;
          end
        end else if (!cur_stb || timeout) begin
          state_d = StIdle;
          ptr_d   = grant_nxt;
        end else begin
          count_d = count_q + TMO_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with asynchronous reset.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= StIdle;
      grant_q <= '0;
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

endmodule
